// File: rtl/pci_bus_sequencer.sv
// pci_bus_sequencer
//   Central round-robin arbiter and bus-phase sequencer for one PCI segment.
//   Grants one initiator at a time, then walks the shared phase code
//   address -> turnaround -> data (burst_len+1 transfers) -> finish -> idle.
//
//   Optional macro: PCI_SEQ_DEVSEL_TIMEOUT_EN
//     When defined, a data phase that sees no devsel for DEVSEL_TIMEOUT
//     cycles ends in finish with an abort pulse (master abort).
//     When undefined, data waits indefinitely and abort is tied low.
//
//   Ports
//     clk        bus clock, rising edge
//     rst        asynchronous active-high reset
//     req_n      active-low bus requests, one per initiator
//     burst_len  data phases minus one, sampled in address
//     devsel     active-low target select (anything but 0 = deasserted)
//     trdy       active-low target ready (anything but 0 = deasserted)
//     gnt_n      active-low grants, at most one low
//     owner      index of the current bus owner
//     state      phase code: 0 idle, 1 address, 2 turnaround, 3 data, 4 finish
//     fvalid     high in address, turnaround and data
//     xfer_done  one-cycle pulse in finish after a normal completion
//     abort      one-cycle pulse in finish after a master abort
module pci_bus_sequencer #(
   parameter int NUM_MASTERS    = 4,
   parameter int DEVSEL_TIMEOUT = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] req_n,
   input  logic [3:0]             burst_len,
   input  logic                   devsel,
   input  logic                   trdy,
   output logic [NUM_MASTERS-1:0] gnt_n,
   output logic [1:0]             owner,
   output logic [2:0]             state,
   output logic                   fvalid,
   output logic                   xfer_done,
   output logic                   abort
);

   if (NUM_MASTERS < 2 || NUM_MASTERS > 4) begin : g_bad_masters
      $error("pci_bus_sequencer: NUM_MASTERS must be 2..4");
   end
   if (DEVSEL_TIMEOUT < 1 || DEVSEL_TIMEOUT > 15) begin : g_bad_timeout
      $error("pci_bus_sequencer: DEVSEL_TIMEOUT must be 1..15");
   end

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_TURN = 3'd2,
      S_DATA = 3'd3,
      S_FIN  = 3'd4
   } phase_t;

   phase_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] gnt_d;
   logic [1:0]             owner_d;
   logic                   fvalid_d;
   logic                   done_d;
   logic [3:0]             remaining, remaining_d;
   logic [1:0]             last_owner, last_owner_d;
   logic                   has_owner, has_owner_d;

   // Only a literal 0 counts as asserted; x/z fall through as deasserted.
   logic devsel_on, trdy_on;
   assign devsel_on = (devsel == 1'b0);
   assign trdy_on   = (trdy == 1'b0);

   assign state = state_q;

   // Round-robin search. has_owner distinguishes "nobody owned the bus
   // since reset" (start at 0) from "master 0 was last" (start at 1).
   logic                   req_any;
   logic [1:0]             win;
   logic [NUM_MASTERS-1:0] win_onehot;
   int unsigned            start;
   int unsigned            idx;

   always_comb begin
      req_any    = 1'b0;
      win        = '0;
      win_onehot = '0;
      idx        = 0;
      if (has_owner && ({30'd0, last_owner} != NUM_MASTERS - 1))
         start = {30'd0, last_owner} + 32'd1;
      else
         start = 0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         idx = start + i;
         if (idx >= NUM_MASTERS)
            idx = idx - NUM_MASTERS;
         if (!req_any && !req_n[idx]) begin
            req_any         = 1'b1;
            win             = idx[1:0];
            win_onehot[idx] = 1'b1;
         end
      end
   end

`ifdef PCI_SEQ_DEVSEL_TIMEOUT_EN
   logic [3:0] tcnt, tcnt_d;
   logic       abort_d;
`endif

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_n;
      owner_d      = owner;
      remaining_d  = remaining;
      last_owner_d = last_owner;
      has_owner_d  = has_owner;
      done_d       = 1'b0;
`ifdef PCI_SEQ_DEVSEL_TIMEOUT_EN
      tcnt_d       = tcnt;
      abort_d      = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            gnt_d = '1;
            if (req_any) begin
               state_d = S_ADDR;
               gnt_d   = ~win_onehot;
               owner_d = win;
            end
         end
         S_ADDR: begin
            remaining_d = burst_len;
            state_d     = S_TURN;
         end
         S_TURN: begin
`ifdef PCI_SEQ_DEVSEL_TIMEOUT_EN
            tcnt_d  = '0;
`endif
            state_d = S_DATA;
         end
         S_DATA: begin
            if (devsel_on) begin
`ifdef PCI_SEQ_DEVSEL_TIMEOUT_EN
               tcnt_d = '0;
`endif
               if (trdy_on) begin
                  if (remaining == 4'd0) begin
                     state_d = S_FIN;
                     done_d  = 1'b1;
                  end else begin
                     remaining_d = remaining - 4'd1;
                  end
               end
            end
`ifdef PCI_SEQ_DEVSEL_TIMEOUT_EN
            // Compare the incremented count so abort lands after exactly
            // DEVSEL_TIMEOUT silent data cycles.
            else if (tcnt + 4'd1 == 4'(DEVSEL_TIMEOUT)) begin
               state_d = S_FIN;
               abort_d = 1'b1;
               tcnt_d  = '0;
            end else begin
               tcnt_d = tcnt + 4'd1;
            end
`endif
         end
         S_FIN: begin
            state_d      = S_IDLE;
            gnt_d        = '1;
            last_owner_d = owner;
            has_owner_d  = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '1;
         end
      endcase
      fvalid_d = (state_d == S_ADDR) || (state_d == S_TURN) || (state_d == S_DATA);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         gnt_n      <= '1;
         owner      <= '0;
         fvalid     <= 1'b0;
         xfer_done  <= 1'b0;
         remaining  <= '0;
         last_owner <= '0;
         has_owner  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_n      <= gnt_d;
         owner      <= owner_d;
         fvalid     <= fvalid_d;
         xfer_done  <= done_d;
         remaining  <= remaining_d;
         last_owner <= last_owner_d;
         has_owner  <= has_owner_d;
      end
   end

`ifdef PCI_SEQ_DEVSEL_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt  <= '0;
         abort <= 1'b0;
      end else begin
         tcnt  <= tcnt_d;
         abort <= abort_d;
      end
   end
`else
   assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_pci_bus_sequencer.sv
module tb_pci_bus_sequencer;
   localparam int NM = 4;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NM-1:0] req_n;
   logic [3:0]    burst_len;
   logic          devsel;
   logic          trdy;
   logic [NM-1:0] gnt_n;
   logic [1:0]    owner;
   logic [2:0]    state;
   logic          fvalid;
   logic          xfer_done;
   logic          abort;

   pci_bus_sequencer #(.NUM_MASTERS(NM), .DEVSEL_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_n(req_n), .burst_len(burst_len),
      .devsel(devsel), .trdy(trdy), .gnt_n(gnt_n), .owner(owner),
      .state(state), .fvalid(fvalid), .xfer_done(xfer_done), .abort(abort)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0] owner;
      logic       aborted;
   } exp_t;
   exp_t sb[$];

   logic [2:0] st_tr[$];
   logic       fv_tr[$];
   logic       xd_tr[$];

   int            r_dcycles;
   logic          r_done, r_abort;
   logic [1:0]    r_owner;
   logic [NM-1:0] r_fin_gnt, r_idle_gnt;
   bit            r_timeout;

   // Drives one transaction and records what the DUT did; checks are done
   // by the callers. release_at: phase in which req_n goes high (-1 = hold).
   task automatic run_txn(input logic [NM-1:0] req, input logic [3:0] blen,
                          input int nodev, input int waits, input int release_at);
      bit seen_fin = 0;
      r_dcycles = 0; r_done = 0; r_abort = 0; r_owner = 0;
      r_fin_gnt = '1; r_idle_gnt = '0; r_timeout = 1;
      st_tr.delete(); fv_tr.delete(); xd_tr.delete();
      req_n = req; burst_len = blen; devsel = 1'b0; trdy = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         st_tr.push_back(state); fv_tr.push_back(fvalid); xd_tr.push_back(xfer_done);
         if (release_at >= 0 && state == 3'(release_at)) req_n = '1;
         if (state == 3'd2) burst_len = ~blen;
         if (state == 3'd3) begin
            r_dcycles++;
            devsel = (r_dcycles <= nodev);
            trdy   = (r_dcycles <= nodev + waits);
         end
         if (state == 3'd4) begin
            seen_fin = 1; r_done = xfer_done; r_abort = abort;
            r_owner = owner; r_fin_gnt = gnt_n;
         end else if (state == 3'd0 && seen_fin) begin
            r_idle_gnt = gnt_n; r_timeout = 0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; req_n = '1; burst_len = '0; devsel = 1'b1; trdy = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
      total++; if (gnt_n !== 4'b1111) begin bad++; $display("FAIL reset_gnt got=%b exp=1111", gnt_n); end
      total++; if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", owner); end
      total++; if (fvalid !== 1'b0) begin bad++; $display("FAIL reset_fvalid got=%b exp=0", fvalid); end
      total++; if (xfer_done !== 1'b0 || abort !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", xfer_done, abort); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (state !== 3'd0) begin bad++; $display("FAIL idle_no_req got=%0d exp=0", state); end
   endtask

   task automatic test_single;
      logic [2:0] es [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
      logic       ef [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic       ed [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_t e;
      sb.push_back('{2'd0, 1'b0});
      run_txn(4'b1110, 4'd0, 0, 0, 1);
      total++; if (r_timeout) begin bad++; $display("FAIL single_timeout got=stuck exp=finish"); end
      total++; if (st_tr.size() != 5) begin bad++; $display("FAIL single_len got=%0d exp=5", st_tr.size()); end
      for (int i = 0; i < 5 && i < st_tr.size(); i++) begin
         total++;
         if (st_tr[i] !== es[i] || fv_tr[i] !== ef[i] || xd_tr[i] !== ed[i]) begin
            bad++;
            $display("FAIL single_cycle%0d got=st%0d/fv%b/xd%b exp=st%0d/fv%b/xd%b",
                     i, st_tr[i], fv_tr[i], xd_tr[i], es[i], ef[i], ed[i]);
         end
      end
      total++; if (r_fin_gnt !== 4'b1110) begin bad++; $display("FAIL single_gnt got=%b exp=1110", r_fin_gnt); end
      total++; if (r_idle_gnt !== 4'b1111) begin bad++; $display("FAIL single_idle_gnt got=%b exp=1111", r_idle_gnt); end
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL single_sb got=empty exp=entry"); end
      else begin
         e = sb.pop_front();
         if (r_owner !== e.owner || r_abort !== e.aborted) begin
            bad++; $display("FAIL single_sb got=own%0d/ab%b exp=own%0d/ab%b", r_owner, r_abort, e.owner, e.aborted);
         end
      end
   endtask

   task automatic test_round_robin;
      exp_t e;
      logic [NM-1:0] eg;
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 4; k++) sb.push_back('{2'(k), 1'b0});
      for (int k = 0; k < 4; k++) begin
         run_txn(4'b0000, 4'd0, 0, 0, -1);
         eg = ~(4'b0001 << k);
         total++; if (r_timeout || st_tr.size() != 5) begin bad++; $display("FAIL rr%0d_len got=%0d exp=5", k, st_tr.size()); end
         total++; if (r_fin_gnt !== eg) begin bad++; $display("FAIL rr%0d_gnt got=%b exp=%b", k, r_fin_gnt, eg); end
         total++;
         if (sb.size() == 0) begin bad++; $display("FAIL rr%0d_sb got=empty exp=entry", k); end
         else begin
            e = sb.pop_front();
            if (r_owner !== e.owner || r_done !== 1'b1) begin
               bad++; $display("FAIL rr%0d_sb got=own%0d/done%b exp=own%0d/done1", k, r_owner, r_done, e.owner);
            end
         end
      end
      req_n = '1;
   endtask

   task automatic test_wait_states;
      exp_t e;
      sb.push_back('{2'd1, 1'b0});
      run_txn(4'b1101, 4'd3, 0, 2, 1);
      total++; if (r_timeout || r_dcycles != 6) begin bad++; $display("FAIL wait_dcycles got=%0d exp=6", r_dcycles); end
      total++; if (r_done !== 1'b1) begin bad++; $display("FAIL wait_done got=%b exp=1", r_done); end
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL wait_sb got=empty exp=entry"); end
      else begin
         e = sb.pop_front();
         if (r_owner !== e.owner || r_abort !== e.aborted) begin
            bad++; $display("FAIL wait_sb got=own%0d/ab%b exp=own%0d/ab%b", r_owner, r_abort, e.owner, e.aborted);
         end
      end
   endtask

   task automatic test_long_burst;
      exp_t e;
      sb.push_back('{2'd0, 1'b0});
      run_txn(4'b1110, 4'd15, 0, 0, 1);
      total++; if (r_timeout || r_dcycles != 16) begin bad++; $display("FAIL burst15_dcycles got=%0d exp=16", r_dcycles); end
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL burst15_sb got=empty exp=entry"); end
      else begin
         e = sb.pop_front();
         if (r_owner !== e.owner || r_done !== 1'b1) begin
            bad++; $display("FAIL burst15_sb got=own%0d/done%b exp=own%0d/done1", r_owner, r_done, e.owner);
         end
      end
   endtask

   task automatic test_timeout;
      exp_t e;
      int   exp_dc;
      logic exp_ab;
`ifdef PCI_SEQ_DEVSEL_TIMEOUT_EN
      exp_dc = TO; exp_ab = 1'b1;
`else
      exp_dc = 7;  exp_ab = 1'b0;
`endif
      sb.push_back('{2'd3, exp_ab});
      run_txn(4'b0111, 4'd0, 6, 0, 1);
      total++; if (r_timeout || r_dcycles != exp_dc) begin bad++; $display("FAIL timeout_dcycles got=%0d exp=%0d", r_dcycles, exp_dc); end
      total++; if (r_done !== ~exp_ab) begin bad++; $display("FAIL timeout_done got=%b exp=%b", r_done, ~exp_ab); end
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL timeout_sb got=empty exp=entry"); end
      else begin
         e = sb.pop_front();
         if (r_owner !== e.owner || r_abort !== e.aborted) begin
            bad++; $display("FAIL timeout_sb got=own%0d/ab%b exp=own%0d/ab%b", r_owner, r_abort, e.owner, e.aborted);
         end
      end
   endtask

   task automatic test_withdraw;
      exp_t e;
      sb.push_back('{2'd2, 1'b0});
      run_txn(4'b1011, 4'd1, 0, 0, 2);
      total++; if (r_timeout || r_dcycles != 2 || r_done !== 1'b1) begin bad++; $display("FAIL withdraw_run got=dc%0d/done%b exp=dc2/done1", r_dcycles, r_done); end
      total++; if (r_fin_gnt !== 4'b1011) begin bad++; $display("FAIL withdraw_fin_gnt got=%b exp=1011", r_fin_gnt); end
      total++; if (r_idle_gnt !== 4'b1111) begin bad++; $display("FAIL withdraw_idle_gnt got=%b exp=1111", r_idle_gnt); end
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL withdraw_sb got=empty exp=entry"); end
      else begin
         e = sb.pop_front();
         if (r_owner !== e.owner) begin bad++; $display("FAIL withdraw_sb got=own%0d exp=own%0d", r_owner, e.owner); end
      end
      @(negedge clk);
      total++; if (state !== 3'd0) begin bad++; $display("FAIL withdraw_stay_idle got=%0d exp=0", state); end
   endtask

   task automatic test_reset_mid;
      exp_t e;
      int   dc = 0;
      bit   reached = 0;
      req_n = 4'b1011; burst_len = 4'd7; devsel = 1'b0; trdy = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (state == 3'd1) req_n = '1;
         if (state == 3'd3) dc++;
         if (dc == 2) begin reached = 1; break; end
      end
      total++; if (!reached) begin bad++; $display("FAIL rstmid_reach got=dc%0d exp=dc2", dc); end
      rst = 1'b1;
      #1;
      total++; if (state !== 3'd0 || fvalid !== 1'b0) begin bad++; $display("FAIL rstmid_state got=st%0d/fv%b exp=st0/fv0", state, fvalid); end
      total++; if (gnt_n !== 4'b1111) begin bad++; $display("FAIL rstmid_gnt got=%b exp=1111", gnt_n); end
      @(negedge clk);
      total++; if (xfer_done !== 1'b0 || abort !== 1'b0) begin bad++; $display("FAIL rstmid_pulses got=%b%b exp=00", xfer_done, abort); end
      rst = 1'b0;
      sb.push_back('{2'd0, 1'b0});
      run_txn(4'b0000, 4'd0, 0, 0, 1);
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL rstmid_sb got=empty exp=entry"); end
      else begin
         e = sb.pop_front();
         if (r_timeout || r_owner !== e.owner || r_done !== 1'b1) begin
            bad++; $display("FAIL rstmid_next_owner got=own%0d/done%b exp=own%0d/done1", r_owner, r_done, e.owner);
         end
      end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_wait_states();
      test_long_burst();
      test_timeout();
      test_withdraw();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pci_bus_sequencer.md
# pci_bus_sequencer

Central arbiter and bus-phase sequencer for the PCI segment. It arbitrates up to four initiators round-robin via active-low REQ/GNT. It drives the shared `state[2:0]` phase code and `fvalid` that all target controllers decode. It counts completed data phases using target `devsel`/`trdy` and terminates each transaction with a one-cycle `finish` phase.

## Interface
Parameters:
- `NUM_MASTERS`, 4 — number of requesters; legal 2..4.
- `DEVSEL_TIMEOUT`, 4 — data-phase cycles without `devsel`==0 before master abort; legal 1..15.

Ports:
- `clk`  in  1  — bus clock, all logic on rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `req_n`  in  NUM_MASTERS  — active-low bus requests.
- `burst_len`  in  4  — data phases minus one, driven by the granted initiator; sampled in `address`.
- `devsel`  in  1  — target select, active-low; any value other than 0 (1 or z) counts as deasserted.
- `trdy`  in  1  — target ready, active-low; same rule as `devsel`.
- `gnt_n`  out  NUM_MASTERS  — active-low grants, at most one low; reset all 1s.
- `owner`  out  2  — index of current bus owner; reset 0.
- `state`  out  3  — phase code: idle=0, address=1, turnaround=2, data=3, finish=4; reset 0.
- `fvalid`  out  1  — high in `address`, `turnaround`, `data`; reset 0.
- `xfer_done`  out  1  — one-cycle pulse in the `finish` cycle after a normal completion; reset 0.
- `abort`  out  1  — one-cycle pulse in the `finish` cycle after a master abort; reset 0.

## Operation
- All outputs are registered.
- `idle`:
  - If any `req_n` bit is 0, select the winner by round-robin. Search starts at `last_owner+1` mod NUM_MASTERS; after reset the search starts at 0.
  - Next cycle: drive that winner's `gnt_n` bit to 0, set `owner`, and set `state`=address.
  - If no requests: stay in `idle` with all grants high.
- `address` (1 cycle): latch `burst_len` into `remaining`; next state is `turnaround`.
- `turnaround` (1 cycle): clear the timeout counter; next state is `data`.
- `data`:
  - Each cycle with `devsel`==0 and `trdy`==0 completes one transfer.
  - When `remaining`==0 and a transfer completes: next state is `finish`, with `xfer_done` pulsed.
  - Otherwise a completed transfer decrements `remaining`.
  - `devsel`==0 with `trdy`!=0 is a wait state; hold everything.
- `finish` (1 cycle): grant is still held. Next state is `idle`, and all `gnt_n` go high on entry to `idle`. `last_owner` is updated to `owner`.
- A request withdrawn after grant does not cancel the transaction; the sequence runs to `finish`.
- Requests are not sampled outside `idle`. Minimum gap between transactions is one `idle` cycle.
- `remaining` is 4 bits and never underflows. `burst_len`=0 gives 1 data phase; `burst_len`=15 gives 16.

## Timing
- Request to grant: `req_n` low in an `idle` cycle gives `gnt_n` low and `state`=1 in the next cycle.
- Minimum transaction is 5 cycles: address, turnaround, one data, finish, idle.
- Each `trdy` wait cycle adds one cycle.
- Simultaneous requests: exactly one grant is issued per `idle` exit. Others stay pending and are served in rotation.
- Reset asserted mid-transaction: immediately `state`=0, `fvalid`=0, grants all 1s, counters and `last_owner` cleared. No `xfer_done` or `abort` pulse is issued.

## Configuration
- `PCI_SEQ_DEVSEL_TIMEOUT_EN` defined:
  - A 4-bit counter runs in `data` while `devsel`!=0.
  - When it reaches DEVSEL_TIMEOUT, next state is `finish` with `abort` pulsed instead of `xfer_done`.
  - The counter clears whenever `devsel`==0.
- Undefined: no timeout logic; `data` waits indefinitely for `devsel`, and `abort` is tied to 0.

## Test plan
- Reset, then `req_n`=4'b1110 and `burst_len`=0, with target asserting `devsel`/`trdy` in `data` → `gnt_n`=1110; `state` 1,2,3,4,0 on consecutive cycles; `xfer_done` pulse in `finish`.
- `req_n`=4'b0000 held for 4 transactions → `owner` sequence 0,1,2,3, one grant per transaction.
- `burst_len`=3 with `trdy` high for 2 cycles in the first data phase → 6 cycles spent in `data`, then `finish`.
- Timeout enabled, no target responds (`devsel`=z) → after 4 `data` cycles `state`=4 and `abort`=1; with the macro undefined, `state` stays 3.
- `rst` pulsed during the second data phase of `burst_len`=7 → `state`=0 and `gnt_n`=1111 in the same cycle; the next grant goes to master 0.
- Requester 2 deasserts `req_n` during `turnaround` → transaction completes normally; `gnt_n[2]` returns to 1 on entry to `idle`.
